pcie_strm_tx_arb: RTL

Parametrised N-channel upstream stream arbiter. It replaces the fixed four-stream user_strN_data_valid_i/ack_o fan-in with a generic NUM_STRM-channel block. It grants one user stream at a time in round-robin order, in bursts of up to MAX_BURST beats, and presents a single registered stream (data, channel id, burst-last) to the PCIe TX packetiser inside pcie_app.

---
 rtl/pcie_strm_pkg.sv | 31 +++
 rtl/pcie_strm_tx_arb_if.sv | 37 +++
 rtl/strm_rr_pick.sv | 38 +++
 rtl/pcie_strm_tx_arb.sv | 116 +++++++++++
 4 files changed

// File: rtl/pcie_strm_pkg.sv
`default_nettype none
// ============================================================================
//  pcie_strm_pkg
//  Shared helpers and FSM encoding for the upstream stream arbiter.
//  Revision: 1.0
// ============================================================================
package pcie_strm_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit id field.
    function automatic int id_width(input int num_strm);
        return (num_strm > 1) ? clog2(num_strm) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pcie_strm_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  pcie_strm_tx_arb_if
//  User-side stream fan-in and single registered output stream.
//  Revision: 1.0
// ============================================================================
interface pcie_strm_tx_arb_if
    import pcie_strm_pkg::*;
#(
    parameter int NUM_STRM   = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int ID_WIDTH = id_width(NUM_STRM);

    logic [NUM_STRM-1:0]            strm_en_i;
    logic [NUM_STRM-1:0]            strm_data_valid_i;
    logic [NUM_STRM-1:0]            strm_ack_o;
    logic [NUM_STRM*DATA_WIDTH-1:0] strm_data_i;
    logic                           out_data_valid_o;
    logic                           out_ready_i;
    logic [DATA_WIDTH-1:0]          out_data_o;
    logic [ID_WIDTH-1:0]            out_strm_id_o;
    logic                           out_last_o;

    // Sources and downstream sink.
    modport master (
        output strm_en_i, strm_data_valid_i, strm_data_i, out_ready_i,
        input  strm_ack_o, out_data_valid_o, out_data_o, out_strm_id_o, out_last_o
    );

    // The arbiter.
    modport slave (
        input  strm_en_i, strm_data_valid_i, strm_data_i, out_ready_i,
        output strm_ack_o, out_data_valid_o, out_data_o, out_strm_id_o, out_last_o
    );
endinterface
`default_nettype wire

// File: rtl/strm_rr_pick.sv
`default_nettype none
// ============================================================================
//  strm_rr_pick
//  Rotating-priority pick: first requester at or after rr_ptr, modulo NUM_STRM.
//  Revision: 1.0
// ============================================================================
module strm_rr_pick
    import pcie_strm_pkg::*;
#(
    parameter int NUM_STRM = 4
) (
    input  wire logic [NUM_STRM-1:0]           req_i,
    input  wire logic [id_width(NUM_STRM)-1:0] rr_ptr_i,
    output logic                               any_req_o,
    output logic [id_width(NUM_STRM)-1:0]      pick_id_o
);
    localparam int ID_WIDTH = id_width(NUM_STRM);

    assign any_req_o = |req_i;

    // Walk from the farthest offset back to rr_ptr so the nearest requester wins.
    always_comb begin
        int w_idx;
        w_idx     = 0;
        pick_id_o = rr_ptr_i;
        for (int i = NUM_STRM - 1; i >= 0; i--) begin
            w_idx = int'(rr_ptr_i) + i;
            if (w_idx >= NUM_STRM) begin
                w_idx = w_idx - NUM_STRM;
            end
            if (|(req_i & (NUM_STRM'(1) << w_idx))) begin
                pick_id_o = ID_WIDTH'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcie_strm_tx_arb.sv
`default_nettype none
// ============================================================================
//  pcie_strm_tx_arb
//  N-channel round-robin burst arbiter feeding one registered output stream.
//  Revision: 1.0
// ============================================================================
module pcie_strm_tx_arb
    import pcie_strm_pkg::*;
#(
    parameter int NUM_STRM   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  wire logic                          pcie_core_clk,
    input  wire logic                          user_reset,
    pcie_strm_tx_arb_if.slave                  bus,
    output logic [id_width(NUM_STRM)-1:0]      grant_id_o,
    output logic                               burst_active_o
);
    localparam int                    ID_WIDTH  = id_width(NUM_STRM);
    localparam int                    CNT_WIDTH = clog2(MAX_BURST) + 1;
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0]   LAST_ID   = ID_WIDTH'(NUM_STRM - 1);

    state_e                 state_q;
    logic [ID_WIDTH-1:0]    rr_ptr_q;
    logic [ID_WIDTH-1:0]    grant_q;
    logic [CNT_WIDTH-1:0]   beat_cnt_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [ID_WIDTH-1:0]    out_id_q;
    logic [DATA_WIDTH-1:0]  out_data_q;

    logic [ID_WIDTH-1:0]    rr_ptr_d;
    logic [NUM_STRM-1:0]    w_req;
    logic                   w_any_req;
    logic [ID_WIDTH-1:0]    w_pick_id;
    logic                   w_can_accept;
    logic                   w_grant_ack;
    logic                   w_xfer;
    logic                   w_beat_last;
    logic [DATA_WIDTH-1:0]  w_grant_data;

    assign w_req        = bus.strm_en_i & bus.strm_data_valid_i;
    assign w_can_accept = !out_valid_q || bus.out_ready_i;
    assign w_grant_ack  = (state_q == BURST) && w_can_accept && bus.strm_en_i[grant_q];
    assign w_xfer       = w_grant_ack && bus.strm_data_valid_i[grant_q];
    assign w_beat_last  = (beat_cnt_q == LAST_CNT);
    assign w_grant_data = bus.strm_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    // Explicit wrap so non-power-of-2 channel counts never reach an unused id.
    assign rr_ptr_d     = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

    strm_rr_pick #(
        .NUM_STRM (NUM_STRM)
    ) u_rr_pick (
        .req_i     (w_req),
        .rr_ptr_i  (rr_ptr_q),
        .any_req_o (w_any_req),
        .pick_id_o (w_pick_id)
    );

    always_comb begin
        bus.strm_ack_o          = '0;
        bus.strm_ack_o[grant_q] = w_grant_ack;
    end

    always_ff @(posedge pcie_core_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
        end else begin
            if (w_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_grant_data;
                out_id_q    <= grant_q;
                out_last_q  <= w_beat_last;
                beat_cnt_q  <= beat_cnt_q + 1'b1;
            end else if (bus.out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (w_any_req) begin
                        grant_q    <= w_pick_id;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    // Full burst, or the output could take a beat but the source had none.
                    if ((w_xfer && w_beat_last) || (w_can_accept && !w_req[grant_q])) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_data_valid_o = out_valid_q;
    assign bus.out_data_o       = out_data_q;
    assign bus.out_strm_id_o    = out_id_q;
    assign bus.out_last_o       = out_last_q;
    assign grant_id_o           = grant_q;
    assign burst_active_o       = (state_q == BURST);

endmodule
`default_nettype wire
